// File: rtl/stream_frame_sink_pkg.sv
// Shared types and constants for the stream_frame_sink terminal stream consumer.
package stream_frame_sink_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/stream_frame_sink_lfsr.sv
// Seeded 16-bit Fibonacci LFSR with an advance enable; only the low nibble is
// exported because that is all the ready throttle compares against.
module stream_frame_sink_lfsr
  import stream_frame_sink_pkg::*;
(
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic       i_adv,
  output logic [3:0] o_rand
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_rand = r_lfsr[3:0];

endmodule

// File: rtl/stream_frame_sink.sv
// AXI-Stream terminal sink: frames words, publishes a modular checksum per frame,
// counts frames and tracks worst in-frame starvation. Macro STREAM_FRAME_SINK_THROTTLE_EN adds LFSR ready throttling.
//
// state | meaning
// HOLD  | single cycle after reset release, not ready
// RUN   | accepting words (ready unless throttled)
// DONE  | checksum published, one-cycle bubble before next frame
module stream_frame_sink
  import stream_frame_sink_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 1152,
  parameter int CNT_W     = 32,
  localparam int IDX_W    = idx_w(FRAME_LEN)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  input  logic [3:0]       throttle_cfg,
  output logic             frame_done,
  output logic [WIDTH-1:0] frame_checksum,
  output logic [CNT_W-1:0] frame_count,
  output logic [IDX_W-1:0] word_idx,
  output logic [CNT_W-1:0] starve_max
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_SAT  = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_in_run;
  logic             w_throttle_ok;
  logic             w_ready;
  logic             w_xfer;
  logic             w_last;
  logic             w_starved;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cks;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_smax;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;

  assign w_in_run = (r_state == RUN);

`ifdef STREAM_FRAME_SINK_THROTTLE_EN
  logic [3:0] w_rand;

  stream_frame_sink_lfsr u_lfsr (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .i_adv    (w_in_run),
    .o_rand   (w_rand)
  );

  assign w_throttle_ok = (w_rand >= throttle_cfg);
`else
  logic w_unused_cfg;

  assign w_unused_cfg  = ^throttle_cfg;
  assign w_throttle_ok = 1'b1;
`endif

  assign w_ready   = w_in_run && w_throttle_ok;
  assign w_xfer    = in0_V_TVALID && w_ready;
  assign w_last    = (r_idx == LAST_IDX);
  // Throttled cycles and the wait for word 0 are not starvation
  assign w_starved = w_ready && !in0_V_TVALID && (r_idx != '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD:    w_state_nxt = RUN;
      RUN:     if (w_xfer && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc  <= '0;
      r_cks  <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_xfer) begin
        if (w_last) begin
          r_cks  <= r_acc + in0_V_TDATA;
          r_acc  <= '0;
          r_idx  <= '0;
          r_cnt  <= r_cnt + CNT_W'(1);
          r_done <= 1'b1;
        end else begin
          r_acc <= r_acc + in0_V_TDATA;
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_run  <= '0;
      r_smax <= '0;
    end else begin
      if ((r_state == DONE) || w_xfer) begin
        r_run <= '0;
      end else if (w_starved && (r_run != RUN_SAT)) begin
        r_run <= r_run + CNT_W'(1);
      end
      // Compares against the pre-edge run, so the max lags the run by one cycle
      if (r_run > r_smax) begin
        r_smax <= r_run;
      end
    end
  end

  assign in0_V_TREADY   = w_ready;
  assign frame_done     = r_done;
  assign frame_checksum = r_cks;
  assign frame_count    = r_cnt;
  assign word_idx       = r_idx;
  assign starve_max     = r_smax;

endmodule

// File: doc/stream_frame_sink.md
Name: stream_frame_sink

Overview:
- AXI-Stream consumer that drains the output side of a streaming FIFO, i.e. the reader end of the FIFO's out_V interface.
- Accepts words, groups them into frames of FRAME_LEN words, and computes a per-frame modular checksum.
- Counts completed frames and records the worst-case input starvation gap.
- Used in FIFO-depth characterisation and in the dataflow test harness as the terminal sink.

Parameters:
WIDTH, 16, TDATA width in bits
FRAME_LEN, 1152, words per frame (>=2)
CNT_W, 32, width of frame and starvation counters

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset; asynchronous, active-low
in0_V_TDATA  in  WIDTH  stream data
in0_V_TVALID  in  1  stream valid
in0_V_TREADY  out  1  stream ready
throttle_cfg  in  4  ready-throttle duty; 0 = never throttle (used only with macro)
frame_done  out  1  one-cycle pulse when a frame checksum is published
frame_checksum  out  WIDTH  sum mod 2^WIDTH of the last completed frame
frame_count  out  CNT_W  number of completed frames
word_idx  out  clog2(FRAME_LEN)  index of the next word expected in the current frame
starve_max  out  CNT_W  longest run of consecutive starved cycles within a frame

Behaviour:
- Reset (async assert, sync deassert): state=HOLD; TREADY=0, frame_done=0, frame_checksum=0, frame_count=0, word_idx=0, starve_max=0, accumulator=0, starve run=0, LFSR=16'hACE1.
- HOLD: lasts exactly one cycle after reset release, TREADY=0, then goes to RUN.
- RUN:
  - TREADY=1, unless throttled (see Optional Feature).
  - Transfer = TVALID & TREADY on a rising edge.
  - On a transfer: accumulator += TDATA (wraps mod 2^WIDTH) and word_idx increments.
  - On the transfer with word_idx==FRAME_LEN-1: frame_checksum <= accumulator+TDATA, accumulator <= 0, word_idx <= 0, frame_count increments (wraps at 2^CNT_W), next state=DONE.
- DONE: exactly one cycle; frame_done=1; TREADY=0 (one-cycle bubble between frames); then RUN.
- frame_done is registered and high only in DONE. frame_checksum is stable from the DONE cycle until the next DONE.
- Starvation:
  - A starved cycle is a cycle in RUN with word_idx!=0, TREADY=1 and TVALID=0.
  - The run counter increments on each starved cycle and saturates at all-ones.
  - The run counter clears on a transfer and in DONE.
  - starve_max <= max(starve_max, run) is evaluated every cycle, so it updates the cycle after the run grows.
  - Gaps before the first word of a frame are not counted.
- TVALID high while TREADY=0 (HOLD, DONE, throttle): no transfer; data must be held by the upstream side.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values.
- Latency: checksum published one cycle after the last word is accepted.

Optional Feature:
- Macro STREAM_FRAME_SINK_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in RUN.
  - In RUN, TREADY = (LFSR[3:0] >= throttle_cfg); throttle_cfg=0 therefore gives TREADY always 1.
  - Throttled cycles are not starved cycles.
- Undefined: no LFSR; throttle_cfg is ignored; TREADY=1 throughout RUN.

Decomposition:
- Package stream_frame_sink_pkg:
  - state enum {HOLD, RUN, DONE}
  - LFSR seed and tap constants
  - IDX_W = clog2(FRAME_LEN) localparam function
- One sub-module: stream_frame_sink_lfsr (seeded LFSR with advance enable), instantiated only under the macro.

Test Plan:
- Reset release, TVALID held 1, FRAME_LEN=4, data 1,2,3,4 -> TREADY=0 in the first cycle, words accepted on cycles 2-5, frame_done pulses on cycle 6 with checksum 10, frame_count=1, TREADY=0 in that cycle.
- WIDTH=16, four words of 16'hFFFF -> checksum 16'hFFFC (wrap-around).
- Frame with TVALID dropped for 5 cycles after word 1, then 3 cycles after word 2 -> starve_max=5; a 7-cycle gap before word 0 of the next frame leaves it at 5.
- Assert ap_rst_n=0 asynchronously after 2 of 4 words, release, send 4 words of value 1 -> checksum 4, frame_count=1.
- Macro defined, throttle_cfg=8, 64 frames of TVALID=1 -> TREADY duty roughly 50%, all checksums correct, starve_max=0; throttle_cfg=0 -> no throttled cycles.
- Macro undefined, throttle_cfg=15 -> TREADY=1 in every RUN cycle.
